// File: rtl/option_pkg.sv
// option_pkg: shared option record type, result-FSM states and round-robin pick helper
package option_pkg;
   typedef struct packed {
      logic [31:0] option_id;
      logic [31:0] sptprice;
      logic [31:0] strike;
      logic [31:0] rate;
      logic [31:0] volatility;
      logic [31:0] otime;
      logic [31:0] otype;
   } option_rec_t;
   localparam int REC_W = $bits(option_rec_t);
   typedef enum logic {R_IDLE, R_HOLD} res_state_t;
   // index of the first set bit of req at or after ptr (wrapping within n), -1 if none
   function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
      int r;
      int j;
      logic [2:0] jb;
      r = -1;
      for (int i = 7; i >= 0; i--) begin
         j = (ptr + i) % n;
         jb = j[2:0];
         if (i < n && req[jb]) r = j;
      end
      return r;
   endfunction
endpackage

// File: rtl/option_fifo.sv
// option_fifo: synchronous record buffer with occupancy count
// Ports: clk, rst (async active-low), push/din write, pop/dout read head, count = entries held.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module option_fifo #(
   parameter int W     = 224,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign dout = mem[rp];
   always_ff @(posedge clk) if (push) mem[wp] <= din;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/option_dispatch.sv
// option_dispatch: buffers option records, round-robin dispatches them to pricing engines, collects results
// Ports: clk, rst (async active-low); rec_valid + record fields in, rec_drop/drop_cnt/fifo_count status;
// eng_start/eng_rec/eng_ack to engines, eng_busy/eng_done/eng_res_* from engines;
// res_valid/res_ready/res_id/res_price result handshake to the transmit path.
module option_dispatch
   import option_pkg::*;
#(
   parameter int NUM_ENG    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rec_valid,
   input  logic [31:0]                   option_id,
   input  logic [31:0]                   sptprice,
   input  logic [31:0]                   strike,
   input  logic [31:0]                   rate,
   input  logic [31:0]                   volatility,
   input  logic [31:0]                   otime,
   input  logic [31:0]                   otype,
   output logic                          rec_drop,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [NUM_ENG-1:0]            eng_start,
   output logic [REC_W-1:0]              eng_rec,
   input  logic [NUM_ENG-1:0]            eng_busy,
   input  logic [NUM_ENG-1:0]            eng_done,
   input  logic [NUM_ENG*32-1:0]         eng_res_id,
   input  logic [NUM_ENG*32-1:0]         eng_res_price,
   output logic [NUM_ENG-1:0]            eng_ack,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [31:0]                   res_id,
   output logic [31:0]                   res_price
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   option_rec_t rec_in, head;
   logic [NUM_ENG-1:0] free;
   logic [31:0] rid [NUM_ENG];
   logic [31:0] rpr [NUM_ENG];
   logic [PW-1:0] rr_ptr, res_ptr, d_k, r_k;
   int d_sel, r_sel;
   logic pop, push;
   res_state_t state;
   for (genvar g = 0; g < NUM_ENG; g++) begin : g_res
      assign rid[g] = eng_res_id[32*g +: 32];
      assign rpr[g] = eng_res_price[32*g +: 32];
   end
   assign rec_in = {option_id, sptprice, strike, rate, volatility, otime, otype};
   // an engine started last cycle has not raised eng_busy yet, so mask it here
   assign free  = ~eng_busy & ~eng_start;
   assign d_sel = rr_pick(8'(free), int'(rr_ptr), NUM_ENG);
   assign r_sel = rr_pick(8'(eng_done), int'(res_ptr), NUM_ENG);
   assign d_k   = PW'(d_sel);
   assign r_k   = PW'(r_sel);
   assign pop   = fifo_count != '0 && d_sel >= 0;
   // a full buffer still accepts when the head leaves in the same cycle
   assign push  = rec_valid && (fifo_count != CW'(FIFO_DEPTH) || pop);
   option_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (rec_in),
      .dout  (head),
      .count (fifo_count)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_start <= '0;
         eng_rec   <= '0;
         rr_ptr    <= '0;
         rec_drop  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         eng_start <= pop ? NUM_ENG'(1) << d_k : '0;
         if (pop) begin
            eng_rec <= head;
            rr_ptr  <= PW'((d_sel + 1) % NUM_ENG);
         end
         rec_drop <= rec_valid && !push;
         if (rec_valid && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= R_IDLE;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_price <= '0;
         eng_ack   <= '0;
         res_ptr   <= '0;
      end else begin
         eng_ack <= '0;
         if (state == R_IDLE && r_sel >= 0) begin
            state     <= R_HOLD;
            res_valid <= 1'b1;
            res_id    <= rid[r_k];
            res_price <= rpr[r_k];
            eng_ack   <= NUM_ENG'(1) << r_k;
            res_ptr   <= PW'((r_sel + 1) % NUM_ENG);
         end else if (state == R_HOLD && res_ready) begin
            state     <= R_IDLE;
            res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_option_dispatch.sv
// tb_option_dispatch: directed scoreboard bench for option_dispatch
module tb_option_dispatch;
   import option_pkg::*;
   localparam int N = 4;
   logic clk, rst, rec_valid, rec_drop, res_valid, res_ready;
   logic [31:0] option_id, sptprice, strike, rate, volatility, otime, otype, res_id, res_price;
   logic [15:0] drop_cnt;
   logic [2:0] fifo_count;
   logic [N-1:0] eng_start, eng_busy, eng_done, eng_ack;
   logic [REC_W-1:0] eng_rec;
   logic [N*32-1:0] eng_res_id, eng_res_price;
   typedef struct {int eng; logic [31:0] id;} st_t;
   st_t sq[$];
   int rq[$];
   int n_cmp = 0;
   int n_err = 0;
   int drops;
   bit rv_q = 1'b0;
   option_dispatch #(.NUM_ENG(N), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .rec_valid(rec_valid),
      .option_id(option_id), .sptprice(sptprice), .strike(strike), .rate(rate),
      .volatility(volatility), .otime(otime), .otype(otype),
      .rec_drop(rec_drop), .drop_cnt(drop_cnt), .fifo_count(fifo_count),
      .eng_start(eng_start), .eng_rec(eng_rec), .eng_busy(eng_busy), .eng_done(eng_done),
      .eng_res_id(eng_res_id), .eng_res_price(eng_res_price), .eng_ack(eng_ack),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_price(res_price)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic option_rec_t mk(input logic [31:0] id);
      option_rec_t r;
      r.option_id  = id;
      r.sptprice   = id ^ 32'h1111_0000;
      r.strike     = id + 32'd7;
      r.rate       = ~id;
      r.volatility = {id[15:0], id[31:16]};
      r.otime      = id * 32'd3;
      r.otype      = {31'd0, id[0]};
      return r;
   endfunction
   function automatic logic [31:0] rid(input int k);
      return 32'h5000_0000 + 32'(k);
   endfunction
   function automatic logic [31:0] rpr(input int k);
      return 32'h7000_0000 + 32'(k * k) + 32'd9;
   endfunction
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [31:0] id);
      option_rec_t r;
      r = mk(id);
      rec_valid = v;
      {option_id, sptprice, strike, rate, volatility, otime, otype} = r;
   endtask
   // one clock; at the falling edge match any start/result against the scoreboard and play the engine side
   task automatic tick();
      st_t e;
      int k;
      @(negedge clk);
      if (eng_start !== '0) begin
         n_cmp++;
         assert (sq.size() != 0) else begin
            n_err++;
            $error("FAIL start_unexpected: observed %b expected no start", eng_start);
         end
         if (sq.size() != 0) begin
            e = sq.pop_front();
            chk("start", {eng_start, eng_rec}, {N'(1) << e.eng, mk(e.id)});
         end
      end
      if (res_valid && !rv_q) begin
         n_cmp++;
         assert (rq.size() != 0) else begin
            n_err++;
            $error("FAIL result_unexpected: observed id %h expected no result", res_id);
         end
         if (rq.size() != 0) begin
            k = rq.pop_front();
            chk("result", {eng_ack, res_id, res_price}, {N'(1) << k, rid(k), rpr(k)});
         end
      end else if (eng_ack !== '0) chk("ack_spurious", eng_ack, 0);
      rv_q = res_valid;
      eng_done = eng_done & ~eng_ack;
   endtask
   initial begin
      rst = 1'b0;
      eng_busy = '0;
      eng_done = '0;
      res_ready = 1'b0;
      drive(1'b0, 32'h0);
      for (int k = 0; k < N; k++) begin
         eng_res_id[k*32 +: 32] = rid(k);
         eng_res_price[k*32 +: 32] = rpr(k);
      end
      tick();
      tick();
      chk("rst_start", eng_start, 0);
      chk("rst_ack", eng_ack, 0);
      chk("rst_drop", {rec_drop, drop_cnt}, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_res", {res_valid, res_id, res_price}, 0);
      chk("rst_rec", eng_rec, 0);
      // single record, accepted on the first edge after reset release
      rst = 1'b1;
      drive(1'b1, 32'h1);
      sq.push_back('{0, 32'h1});
      tick();
      chk("t1_count_in", fifo_count, 1);
      drive(1'b0, 32'h0);
      tick();
      chk("t1_start", eng_start, 4'b0001);
      chk("t1_id", eng_rec[223:192], 32'h1);
      chk("t1_otype", eng_rec[31:0], 32'h1);
      chk("t1_count_out", fifo_count, 0);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      // four back-to-back records spread over all engines
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h10 + i);
         sq.push_back('{i, 32'h10 + i});
         tick();
      end
      drive(1'b0, 32'h0);
      tick();
      chk("t2_last_start", eng_start, 4'b1000);
      tick();
      chk("t2_sq_empty", sq.size(), 0);
      // all engines busy: fill, overflow, then full-with-pop
      eng_busy = 4'b1111;
      drops = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h20 + i);
         if (i < 4) sq.push_back('{(i + 2) % 4, 32'h20 + i});
         tick();
         drops += int'(rec_drop);
      end
      chk("t3_drops", drops, 2);
      chk("t3_drop_cnt", drop_cnt, 2);
      chk("t3_full", fifo_count, 4);
      eng_busy = 4'b1011;
      drive(1'b1, 32'h26);
      sq.push_back('{2, 32'h26});
      tick();
      chk("t3_start2", eng_start, 4'b0100);
      chk("t3_nodrop", rec_drop, 0);
      chk("t3_pushpop", fifo_count, 4);
      drive(1'b0, 32'h0);
      eng_busy = 4'b1111;
      tick();
      tick();
      chk("t3_stall", fifo_count, 4);
      eng_busy = 4'b0000;
      repeat (6) tick();
      chk("t3_drained", fifo_count, 0);
      chk("t3_sq_empty", sq.size(), 0);
      // two engines done together, transmit always ready
      eng_done = 4'b0101;
      res_ready = 1'b1;
      rq.push_back(0);
      rq.push_back(2);
      repeat (6) tick();
      chk("t4_idle", res_valid, 0);
      chk("t4_acked", eng_done, 0);
      chk("t4_rq_empty", rq.size(), 0);
      // transmit stalled: result held, no further grant
      eng_done = 4'b0010;
      res_ready = 1'b0;
      rq.push_back(1);
      tick();
      eng_done[3] = 1'b1;
      rq.push_back(3);
      repeat (10) begin
         tick();
         chk("t5_hold", {res_valid, res_id, res_price, eng_ack}, {1'b1, rid(1), rpr(1), 4'b0000});
      end
      res_ready = 1'b1;
      tick();
      chk("t5_release", res_valid, 0);
      repeat (3) tick();
      chk("t5_rq_empty", rq.size(), 0);
      // reset mid-operation with buffered records and a held result
      eng_busy = 4'b1111;
      eng_done = 4'b0001;
      res_ready = 1'b0;
      rq.push_back(0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40 + i);
         tick();
      end
      drive(1'b0, 32'h0);
      chk("t6_buffered", fifo_count, 3);
      chk("t6_held", res_valid, 1);
      rst = 1'b0;
      eng_done = '0;
      tick();
      chk("t6_rst_start", {eng_start, eng_ack}, 0);
      chk("t6_rst_drop", {rec_drop, drop_cnt}, 0);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_res", {res_valid, res_id, res_price}, 0);
      chk("t6_rst_rec", eng_rec, 0);
      rst = 1'b1;
      eng_busy = '0;
      drive(1'b1, 32'h50);
      sq.push_back('{0, 32'h50});
      tick();
      drive(1'b0, 32'h0);
      tick();
      chk("t6_start0", eng_start, 4'b0001);
      repeat (3) tick();
      chk("end_sq_empty", sq.size(), 0);
      chk("end_rq_empty", rq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/option_dispatch.md
OPTION_DISPATCH -- requirements
Module: option_dispatch

Interface
REQ-001 Parameter NUM_ENG, default 4, number of pricing engines served (2..8).
REQ-002 Parameter FIFO_DEPTH, default 4, record buffer depth (power of two).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 rec_valid  in  1  one-cycle pulse: parsed option record present.
REQ-007 option_id, sptprice, strike, rate, volatility, otime, otype  in  32 each  record fields, sampled when rec_valid=1.
REQ-008 rec_drop  out  1  one-cycle pulse: incoming record lost (buffer full).
REQ-009 drop_cnt  out  16  saturating count of dropped records.
REQ-010 fifo_count  out  $clog2(FIFO_DEPTH)+1  records buffered.
REQ-011 eng_start  out  NUM_ENG  one-hot one-cycle start pulse to engine k.
REQ-012 eng_rec  out  224  packed record for the started engine, valid with eng_start.
REQ-013 eng_busy  in  NUM_ENG  engine k is computing or holding a result.
REQ-014 eng_done  in  NUM_ENG  engine k holds a result; level, held until acked.
REQ-015 eng_res_id, eng_res_price  in  NUM_ENG*32 each  per-engine result id and price.
REQ-016 eng_ack  out  NUM_ENG  one-hot one-cycle pulse: result of engine k taken.
REQ-017 res_valid / res_ready  out / in  1  result handshake to the transmit path.
REQ-018 res_id, res_price  out  32 each  result payload, stable while res_valid=1.

Function
REQ-019 On rec_valid with fifo_count<FIFO_DEPTH, or with fifo full and a dispatch pop in the same cycle, the record SHALL be pushed; otherwise rec_drop pulses the next cycle and drop_cnt increments, saturating at 0xFFFF.
REQ-020 An engine is free when eng_busy[k]=0 and eng_start[k] was not asserted in the previous cycle.
REQ-021 When the FIFO is non-empty and any engine is free, the block SHALL select the first free engine at or after rr_ptr (wrapping), assert eng_start[k] with eng_rec = FIFO head in the next cycle, pop the head, and set rr_ptr = k+1 mod NUM_ENG.
REQ-022 Minimum latency rec_valid -> eng_start: 2 cycles with an empty FIFO and an idle engine; at most one start per cycle.
REQ-023 No engine free: the head SHALL stay in the FIFO, no eng_start.
REQ-024 Result FSM states: R_IDLE, R_HOLD.
REQ-025 R_IDLE: if any eng_done, grant the first k at or after res_ptr, register eng_res_id[k]/eng_res_price[k] into res_id/res_price, set res_valid=1, pulse eng_ack[k], set res_ptr=k+1, and go to R_HOLD.
REQ-026 R_HOLD: res_valid and payload SHALL be held until res_ready=1; on that edge clear res_valid and return to R_IDLE. Minimum one idle cycle between results.
REQ-027 Dispatch and result paths SHALL operate independently in the same cycle.
REQ-028 Record packing: option_id in bits [223:192], then sptprice, strike, rate, volatility, otime, with otype in bits [31:0].

Reset
REQ-029 While rst=0, the block SHALL hold all outputs at 0, FIFO empty, rr_ptr=res_ptr=0, FSM=R_IDLE, drop_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard buffered records and any held result without an eng_ack pulse.
REQ-031 The first rec_valid SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-032 Shared package option_pkg SHALL hold option_rec_t (7x32 packed struct), REC_W=224, and the result-state enum.
REQ-033 Record buffer SHALL be sub-module option_fifo (synchronous, parameterised width/depth, count output).

Verification
REQ-034 Single record id=0x1, all engines idle -> eng_start=4'b0001 two cycles later, eng_rec[223:192]=0x1, fifo_count back to 0.
REQ-035 Four back-to-back records, all engines idle -> eng_start 0001, 0010, 0100, 1000 on consecutive cycles.
REQ-036 eng_busy=4'b1111, six records -> four buffered, two rec_drop pulses, drop_cnt=2; release engine 2 -> next start goes to engine 2 with the first record.
REQ-037 eng_done=4'b0101 simultaneously, res_ready=1 -> results from engine 0 then engine 2, each with an eng_ack pulse, then res_valid=0.
REQ-038 res_ready held 0 for 10 cycles with res_valid=1 -> res_id/res_price unchanged and no further eng_ack.
REQ-039 rst asserted with 3 buffered records -> all outputs 0, fifo_count=0; a new record after release dispatches to engine 0.
